// File: rtl/ucsbece154b_perf_monitor.sv
// Cycle/instruction counter and program-end detector for the N-wide core.
// Optional issue-width histogram is enabled by defining PERF_HIST_EN.
module ucsbece154b_perf_monitor #(
    parameter int          LANES       = 2,
    parameter int          WIDTH       = 32,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013,
    parameter int          HALT_REPEAT = 1,
    parameter int          MAX_CYCLES  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear_i,
    input  logic                       start_i,
    input  logic                       stall_d_i,
    input  logic [LANES*32-1:0]        pcf_i,
    input  logic [LANES*32-1:0]        instrf_i,
    input  logic [LANES*32-1:0]        instrd_i,
    output logic [WIDTH-1:0]           cycle_count_o,
    output logic [WIDTH-1:0]           instr_count_o,
    output logic                       running_o,
    output logic                       done_o,
    output logic                       timeout_o,
    output logic [(LANES+1)*WIDTH-1:0] hist_o
);

    localparam int              CW          = $clog2(LANES + 1);
    localparam logic [WIDTH-1:0] ONES        = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] LIMIT       = WIDTH'(MAX_CYCLES);
    localparam logic [31:0]      HALT_TARGET = 32'(HALT_REPEAT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_next;
    logic [WIDTH-1:0]    cycle_count, instr_count, cycle_next, instr_next;
    logic [WIDTH:0]      instr_sum;
    logic [31:0]         halt_ctr, halt_next;
    logic [LANES*32-1:0] prev_pc;
    logic                prev_valid;
    logic                timeout, timeout_next;
    logic [LANES-1:0]    useful;
    logic [CW-1:0]       useful_cnt;
    logic                all_spin, halt_hit, limit_hit;

    always_comb begin
        useful     = '0;
        useful_cnt = '0;
        all_spin   = prev_valid;
        for (int k = 0; k < LANES; k++) begin
            useful[k]  = (instrd_i[32*k +: 32] != 32'b0) &&
                         (instrd_i[32*k +: 32] != NOP_INSTR) && !stall_d_i;
            useful_cnt = useful_cnt + CW'(useful[k]);
            if ((pcf_i[32*k +: 32] != prev_pc[32*k +: 32]) ||
                (instrf_i[32*k +: 32] != NOP_INSTR))
                all_spin = 1'b0;
        end
    end

    // Both counters saturate instead of wrapping so long runs stay monotonic.
    always_comb begin
        cycle_next = (cycle_count == ONES) ? ONES : cycle_count + WIDTH'(1);
        instr_sum  = {1'b0, instr_count} + (WIDTH+1)'(useful_cnt);
        instr_next = instr_sum[WIDTH] ? ONES : instr_sum[WIDTH-1:0];
        halt_next  = all_spin ? halt_ctr + 32'd1 : 32'd0;
        halt_hit   = all_spin && ((halt_ctr + 32'd1) == HALT_TARGET);
        limit_hit  = (MAX_CYCLES != 0) && (cycle_next == LIMIT);
    end

    always_comb begin
        state_next   = state;
        timeout_next = timeout;
        case (state)
            IDLE: if (start_i) state_next = RUN;
            RUN: begin
                if (halt_hit) begin
                    state_next   = DONE;
                    timeout_next = 1'b0;
                end else if (limit_hit) begin
                    state_next   = DONE;
                    timeout_next = 1'b1;
                end
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            timeout     <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
            halt_ctr    <= '0;
            prev_pc     <= '0;
            prev_valid  <= 1'b0;
        end else if (clear_i) begin
            state       <= IDLE;
            timeout     <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
            halt_ctr    <= '0;
            prev_pc     <= '0;
            prev_valid  <= 1'b0;
        end else begin
            state   <= state_next;
            timeout <= timeout_next;
            if (state == RUN) begin
                cycle_count <= cycle_next;
                instr_count <= instr_next;
                halt_ctr    <= halt_next;
                prev_pc     <= pcf_i;
                prev_valid  <= 1'b1;
            end
        end
    end

`ifdef PERF_HIST_EN
    logic [WIDTH-1:0] bins [LANES+1];

    // One bin per possible useful-lane count; the bin for this cycle's count bumps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n <= LANES; n++) bins[n] <= '0;
        end else if (clear_i) begin
            for (int n = 0; n <= LANES; n++) bins[n] <= '0;
        end else if (state == RUN) begin
            bins[useful_cnt] <= (bins[useful_cnt] == ONES) ? ONES
                                                            : bins[useful_cnt] + WIDTH'(1);
        end
    end

    always_comb begin
        hist_o = '0;
        for (int n = 0; n <= LANES; n++) hist_o[n*WIDTH +: WIDTH] = bins[n];
    end
`else
    assign hist_o = '0;
`endif

    assign cycle_count_o = cycle_count;
    assign instr_count_o = instr_count;
    assign running_o     = (state == RUN);
    assign done_o        = (state == DONE);
    assign timeout_o     = timeout;

endmodule

// File: tb/tb_ucsbece154b_perf_monitor.sv
// Self-checking bench for ucsbece154b_perf_monitor: two instances (no limit, limit 50)
// compared every cycle against an integer-level model, plus literal spot checks.
module tb_ucsbece154b_perf_monitor;

   localparam int          LANES       = 2;
   localparam int          WIDTH       = 32;
   localparam logic [31:0] NOP         = 32'h00000013;
   localparam logic [31:0] ADDI        = 32'h00100093;
   localparam logic [31:0] ALU         = 32'h00500113;
   localparam int          HALT_REPEAT = 1;
   localparam longint      MAXV        = 64'h00000000FFFFFFFF;

   logic clk, reset, clear, start, stall;
   logic [LANES*32-1:0] pcf, instrf, instrd;

   logic [WIDTH-1:0] cc0, ic0, cc1, ic1;
   logic run0, done0, to0, run1, done1, to1;
   logic [(LANES+1)*WIDTH-1:0] hist0, hist1;

   int tests = 0;
   int fails = 0;

   ucsbece154b_perf_monitor #(.LANES(LANES), .WIDTH(WIDTH), .NOP_INSTR(NOP),
                              .HALT_REPEAT(HALT_REPEAT), .MAX_CYCLES(0)) dut (
      .clk(clk), .reset(reset), .clear_i(clear), .start_i(start), .stall_d_i(stall),
      .pcf_i(pcf), .instrf_i(instrf), .instrd_i(instrd),
      .cycle_count_o(cc0), .instr_count_o(ic0), .running_o(run0), .done_o(done0),
      .timeout_o(to0), .hist_o(hist0));

   ucsbece154b_perf_monitor #(.LANES(LANES), .WIDTH(WIDTH), .NOP_INSTR(NOP),
                              .HALT_REPEAT(HALT_REPEAT), .MAX_CYCLES(50)) dutLimit (
      .clk(clk), .reset(reset), .clear_i(clear), .start_i(start), .stall_d_i(stall),
      .pcf_i(pcf), .instrf_i(instrf), .instrd_i(instrd),
      .cycle_count_o(cc1), .instr_count_o(ic1), .running_o(run1), .done_o(done1),
      .timeout_o(to1), .hist_o(hist1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: 0 idle, 1 run, 2 done; counts kept as plain integers.
   int          mState [2]      = '{0, 0};
   longint      mCycle [2]      = '{0, 0};
   longint      mInstr [2]      = '{0, 0};
   int          mSpinRun [2]    = '{0, 0};
   bit          mPrevValid [2]  = '{0, 0};
   bit          mTimeout [2]    = '{0, 0};
   bit [31:0]   mPrevPc [2][LANES];
   longint      mBins [2][LANES+1];
   int          mLimit [2]      = '{0, 50};

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset(input int i);
      mState[i] = 0; mCycle[i] = 0; mInstr[i] = 0; mSpinRun[i] = 0;
      mPrevValid[i] = 0; mTimeout[i] = 0;
      for (int k = 0; k < LANES; k++) mPrevPc[i][k] = 0;
      for (int n = 0; n <= LANES; n++) mBins[i][n] = 0;
   endtask

   task automatic modelStep(input int i);
      int  nUseful;
      bit  spinning;
      bit  halted, timed;
      logic [31:0] d, p, f;
      if (clear) begin
         modelReset(i);
         return;
      end
      if (mState[i] == 0) begin
         if (start) mState[i] = 1;
      end else if (mState[i] == 1) begin
         nUseful  = 0;
         spinning = mPrevValid[i];
         for (int k = 0; k < LANES; k++) begin
            d = instrd[32*k +: 32];
            p = pcf[32*k +: 32];
            f = instrf[32*k +: 32];
            if (!stall && d != 0 && d != NOP) nUseful++;
            if (!(p == mPrevPc[i][k] && f == NOP)) spinning = 0;
         end
         mCycle[i] = (mCycle[i] + 1 > MAXV) ? MAXV : mCycle[i] + 1;
         mInstr[i] = (mInstr[i] + nUseful > MAXV) ? MAXV : mInstr[i] + nUseful;
         if (mBins[i][nUseful] < MAXV) mBins[i][nUseful]++;
         mSpinRun[i] = spinning ? mSpinRun[i] + 1 : 0;
         halted = (mSpinRun[i] >= HALT_REPEAT);
         timed  = (mLimit[i] != 0) && (mCycle[i] == mLimit[i]);
         if (halted) begin
            mState[i] = 2; mTimeout[i] = 0;
         end else if (timed) begin
            mState[i] = 2; mTimeout[i] = 1;
         end
         for (int k = 0; k < LANES; k++) mPrevPc[i][k] = pcf[32*k +: 32];
         mPrevValid[i] = 1;
      end
   endtask

   function automatic logic [(LANES+1)*WIDTH-1:0] expectedHist(input int i);
      logic [(LANES+1)*WIDTH-1:0] h;
      h = '0;
`ifdef PERF_HIST_EN
      for (int n = 0; n <= LANES; n++) h[n*WIDTH +: WIDTH] = mBins[i][n][WIDTH-1:0];
`endif
      return h;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         modelReset(0);
         modelReset(1);
      end else begin
         modelStep(0);
         modelStep(1);
      end
   end

   // Every falling edge the registered outputs of both instances must match the model.
   always @(negedge clk) begin
      checkOutput("cycle0", cc0, mCycle[0]);
      checkOutput("instr0", ic0, mInstr[0]);
      checkOutput("running0", run0, mState[0] == 1);
      checkOutput("done0", done0, mState[0] == 2);
      checkOutput("timeout0", to0, mTimeout[0]);
      checkOutput("hist0", hist0, expectedHist(0));
      checkOutput("cycle1", cc1, mCycle[1]);
      checkOutput("instr1", ic1, mInstr[1]);
      checkOutput("running1", run1, mState[1] == 1);
      checkOutput("done1", done1, mState[1] == 2);
      checkOutput("timeout1", to1, mTimeout[1]);
      checkOutput("hist1", hist1, expectedHist(1));
   end

   logic [31:0] pc = 32'h1000;

   task automatic applyStimulus(input bit st, input bit cl, input bit sl,
                                input logic [31:0] p0, input logic [31:0] p1,
                                input logic [31:0] f0, input logic [31:0] f1,
                                input logic [31:0] d0, input logic [31:0] d1);
      start  = st;
      clear  = cl;
      stall  = sl;
      pcf    = {p1, p0};
      instrf = {f1, f0};
      instrd = {d1, d0};
      @(posedge clk);
      #3;
   endtask

   task automatic runNormal(input int n, input logic [31:0] d0, input logic [31:0] d1);
      for (int j = 0; j < n; j++) begin
         applyStimulus(0, 0, 0, pc, pc + 4, ALU, ALU, d0, d1);
         pc = pc + 8;
      end
   endtask

   task automatic idleCycle(input bit cl, input bit st);
      applyStimulus(st, cl, 0, pc, pc + 4, ALU, ALU, 32'h0, 32'h0);
      pc = pc + 8;
   endtask

   initial begin
      logic [31:0] rp0, rp1, rd0, rd1;
      reset = 1'b0; clear = 0; start = 0; stall = 0;
      pcf = '0; instrf = '0; instrd = '0;
      repeat (2) @(posedge clk);
      #3;
      checkOutput("reset_cycle", cc0, 0);
      checkOutput("reset_running", run0, 0);
      reset = 1'b1;

      // Ten cycles, one useful lane each.
      idleCycle(0, 1);
      runNormal(10, ADDI, 32'h0);
      checkOutput("t1_cycle", cc0, 10);
      checkOutput("t1_instr", ic0, 10);
      checkOutput("t1_running", run0, 1);

      idleCycle(1, 0);
      checkOutput("clear_cycle", cc0, 0);

      // Five normal cycles, then both lanes spin on NOP at 0x40/0x44.
      idleCycle(0, 1);
      runNormal(5, ADDI, ADDI);
      applyStimulus(0, 0, 0, 32'h40, 32'h44, NOP, NOP, NOP, NOP);
      applyStimulus(0, 0, 0, 32'h40, 32'h44, NOP, NOP, NOP, NOP);
      checkOutput("halt_done", done0, 1);
      checkOutput("halt_timeout", to0, 0);
      checkOutput("halt_cycle", cc0, 7);
      checkOutput("halt_instr", ic0, 10);
      for (int j = 0; j < 20; j++)
         applyStimulus(1, 0, 1'($urandom % 2), $urandom, $urandom, ALU, ALU, ADDI, ADDI);
      checkOutput("frozen_cycle", cc0, 7);
      checkOutput("frozen_instr", ic0, 10);
      checkOutput("frozen_done", done0, 1);

      // Cycle limit 50 reached with PCs always advancing.
      idleCycle(1, 0);
      idleCycle(0, 1);
      runNormal(60, ADDI, 32'h0);
      checkOutput("limit_done", done1, 1);
      checkOutput("limit_timeout", to1, 1);
      checkOutput("limit_cycle", cc1, 50);
      checkOutput("nolimit_cycle", cc0, 60);

      // Halt lands exactly on cycle 50: halt wins.
      idleCycle(1, 0);
      idleCycle(0, 1);
      runNormal(48, ADDI, ADDI);
      applyStimulus(0, 0, 0, 32'h2000, 32'h2004, NOP, NOP, ADDI, ADDI);
      applyStimulus(0, 0, 0, 32'h2000, 32'h2004, NOP, NOP, ADDI, ADDI);
      checkOutput("tie_done", done1, 1);
      checkOutput("tie_timeout", to1, 0);
      checkOutput("tie_cycle", cc1, 50);

      // Stalls on 3 of 8 cycles, then one lane carrying a NOP.
      idleCycle(1, 0);
      idleCycle(0, 1);
      for (int j = 0; j < 8; j++) begin
         applyStimulus(0, 0, (j == 1 || j == 4 || j == 6), pc, pc + 4, ALU, ALU, ADDI, ALU);
         pc = pc + 8;
      end
      checkOutput("stall_instr", ic0, 10);
      runNormal(1, ADDI, NOP);
      checkOutput("nop_lane_instr", ic0, 11);
      checkOutput("nop_lane_cycle", cc0, 9);

      // Reset mid-run must clear everything without a clock edge.
      idleCycle(1, 0);
      idleCycle(0, 1);
      runNormal(6, ADDI, ADDI);
      reset = 1'b0;
      #1;
      checkOutput("async_cycle", cc0, 0);
      checkOutput("async_instr", ic0, 0);
      checkOutput("async_running", run0, 0);
      checkOutput("async_done", done0, 0);
      @(posedge clk);
      #3;
      reset = 1'b1;

`ifdef PERF_HIST_EN
      idleCycle(1, 0);
      idleCycle(0, 1);
      runNormal(1, ADDI, ADDI);
      runNormal(1, ADDI, 32'h0);
      runNormal(1, 32'h0, NOP);
      runNormal(1, ADDI, ADDI);
      checkOutput("hist_bin0", hist0[WIDTH-1:0], 1);
      checkOutput("hist_bin1", hist0[2*WIDTH-1:WIDTH], 1);
      checkOutput("hist_bin2", hist0[3*WIDTH-1:2*WIDTH], 2);
      checkOutput("hist_cycle", cc0, 4);
`else
      idleCycle(1, 0);
      idleCycle(0, 1);
      runNormal(4, ADDI, ADDI);
      checkOutput("hist_off", hist0, 0);
`endif

      // Random traffic with frequent spinning PCs and occasional clears.
      idleCycle(1, 0);
      rp0 = pc; rp1 = pc + 4;
      for (int j = 0; j < 400; j++) begin
         if ($urandom % 3 != 0) begin
            rp0 = pc; rp1 = pc + 4; pc = pc + 8;
         end
         case ($urandom % 3)
            0: rd0 = 32'h0;
            1: rd0 = NOP;
            default: rd0 = $urandom;
         endcase
         case ($urandom % 3)
            0: rd1 = 32'h0;
            1: rd1 = NOP;
            default: rd1 = $urandom;
         endcase
         applyStimulus(($urandom % 8 == 0), ($urandom % 50 == 0), ($urandom % 4 == 0),
                       rp0, rp1, ($urandom % 2) ? NOP : ALU, ($urandom % 4 != 0) ? NOP : ALU,
                       rd0, rd1);
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
